// File: rtl/pipeline_step_ctrl.sv
// pipeline_step_ctrl: execution controller for the five-stage MIPS pipeline.
// Drives the common step enable and the pipeline reset pulse, executes byte
// commands from the debug unit (R run, S step, P pause, X pipeline reset) and
// counts executed pipeline cycles.
// Optional: define STEP_CTRL_WATCHDOG_EN to build a run-length watchdog that
// forces HALTED after WATCHDOG_LIMIT consecutive RUN cycles.
module pipeline_step_ctrl #(
   parameter int unsigned BITS_SIZE      = 32,
   parameter int unsigned RESET_CYCLES   = 4,
   parameter int unsigned WATCHDOG_LIMIT = 1000000
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_cmd_valid,
   input  logic [7:0]           i_cmd,
   output logic                 o_cmd_ready,
   input  logic                 i_wb_halt,
   output logic                 o_step,
   output logic                 o_pipe_reset,
   output logic [2:0]           o_state,
   output logic [BITS_SIZE-1:0] o_cycle_count,
   output logic                 o_step_done,
   output logic                 o_cmd_error,
   output logic                 o_timeout
);

   localparam logic [7:0] CmdRun   = 8'h52;
   localparam logic [7:0] CmdStep  = 8'h53;
   localparam logic [7:0] CmdPause = 8'h50;
   localparam logic [7:0] CmdReset = 8'h58;

   // PRESET counts down from RESET_CYCLES-1 to 0, one state cycle per value.
   localparam logic [7:0] PresetLast = 8'(RESET_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StRun    = 3'd1,
      StStep   = 3'd2,
      StHalted = 3'd3,
      StPreset = 3'd4
   } state_e;

   state_e               state_q;
   logic [7:0]           preset_cnt_q;
   logic [BITS_SIZE-1:0] cycle_count_q;
   logic                 step_done_q;
   logic                 cmd_error_q;
   logic                 cmd_accept;
   logic                 cmd_known;
   logic                 step_active;
   logic                 halt_now;

`ifdef STEP_CTRL_WATCHDOG_EN
   logic [31:0] run_cnt_q;
   logic        timeout_q;
   logic        wd_expire;

   // Watchdog fires on the RUN cycle that completes WATCHDOG_LIMIT cycles.
   always_comb begin
      wd_expire = (state_q == StRun) && (run_cnt_q == 32'(WATCHDOG_LIMIT - 1));
   end

   assign o_timeout = timeout_q;
`else
   logic unused_wd_limit;
   assign unused_wd_limit = ^WATCHDOG_LIMIT;
   assign o_timeout       = 1'b0;
`endif

   // Command handshake decode and Moore outputs from the state register.
   always_comb begin
      o_cmd_ready  = (state_q == StIdle) || (state_q == StRun) || (state_q == StHalted);
      cmd_accept   = i_cmd_valid && o_cmd_ready;
      cmd_known    = (i_cmd == CmdRun) || (i_cmd == CmdStep) ||
                     (i_cmd == CmdPause) || (i_cmd == CmdReset);
      step_active  = (state_q == StRun) || (state_q == StStep);
      o_step       = step_active;
      o_pipe_reset = (state_q == StPreset);
      o_state      = state_q;
`ifdef STEP_CTRL_WATCHDOG_EN
      halt_now     = i_wb_halt || wd_expire;
`else
      halt_now     = i_wb_halt;
`endif
   end

   assign o_cycle_count = cycle_count_q;
   assign o_step_done   = step_done_q;
   assign o_cmd_error   = cmd_error_q;

   // Controller FSM with cycle counter and registered status pulses.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q       <= StIdle;
         preset_cnt_q  <= '0;
         cycle_count_q <= '0;
         step_done_q   <= 1'b0;
         cmd_error_q   <= 1'b0;
`ifdef STEP_CTRL_WATCHDOG_EN
         run_cnt_q     <= '0;
         timeout_q     <= 1'b0;
`endif
      end else begin
         step_done_q <= (state_q == StStep);
         cmd_error_q <= cmd_accept && !cmd_known;

         // Saturating count of step edges; a PRESET entry below overrides it.
         if (step_active && (cycle_count_q != '1)) begin
            cycle_count_q <= cycle_count_q + 1'b1;
         end

         unique case (state_q)
            StIdle: begin
               if (cmd_accept) begin
                  case (i_cmd)
                     CmdRun: begin
                        state_q <= StRun;
`ifdef STEP_CTRL_WATCHDOG_EN
                        run_cnt_q <= '0;
`endif
                     end
                     CmdStep: state_q <= StStep;
                     CmdReset: begin
                        state_q       <= StPreset;
                        preset_cnt_q  <= PresetLast;
                        cycle_count_q <= '0;
`ifdef STEP_CTRL_WATCHDOG_EN
                        timeout_q     <= 1'b0;
`endif
                     end
                     default: ;
                  endcase
               end
            end

            StRun: begin
`ifdef STEP_CTRL_WATCHDOG_EN
               if (wd_expire) begin
                  timeout_q <= 1'b1;
               end
               run_cnt_q <= run_cnt_q + 32'd1;
`endif
               // Halt wins over any command accepted in the same cycle.
               if (halt_now) begin
                  state_q <= StHalted;
               end else if (cmd_accept && (i_cmd == CmdReset)) begin
                  state_q       <= StPreset;
                  preset_cnt_q  <= PresetLast;
                  cycle_count_q <= '0;
`ifdef STEP_CTRL_WATCHDOG_EN
                  timeout_q     <= 1'b0;
`endif
               end else if (cmd_accept && (i_cmd == CmdPause)) begin
                  state_q <= StIdle;
               end
            end

            StStep: begin
               state_q <= i_wb_halt ? StHalted : StIdle;
            end

            StHalted: begin
               if (cmd_accept && (i_cmd == CmdReset)) begin
                  state_q       <= StPreset;
                  preset_cnt_q  <= PresetLast;
                  cycle_count_q <= '0;
`ifdef STEP_CTRL_WATCHDOG_EN
                  timeout_q     <= 1'b0;
`endif
               end
            end

            StPreset: begin
               if (preset_cnt_q == 8'd0) begin
                  state_q <= StIdle;
               end else begin
                  preset_cnt_q <= preset_cnt_q - 8'd1;
               end
            end

            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_step_ctrl.sv
// Scoreboard bench for pipeline_step_ctrl: the driver pushes the hand-computed
// expected outputs for the cycle following each edge, a monitor pops and
// compares them on the falling edge.
module tb_pipeline_step_ctrl;

   localparam int unsigned BITS = 4;
`ifdef STEP_CTRL_WATCHDOG_EN
   localparam int unsigned WD = 8;
`else
   localparam int unsigned WD = 1000000;
`endif

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RUN  = 3'd1;
   localparam logic [2:0] S_STEP = 3'd2;
   localparam logic [2:0] S_HALT = 3'd3;
   localparam logic [2:0] S_PRE  = 3'd4;

   localparam logic [7:0] C_R = 8'h52;
   localparam logic [7:0] C_S = 8'h53;
   localparam logic [7:0] C_P = 8'h50;
   localparam logic [7:0] C_X = 8'h58;
   localparam logic [7:0] C_BAD = 8'h41;

   logic            clk = 1'b0;
   logic            rst;
   logic            cmd_valid;
   logic [7:0]      cmd;
   logic            cmd_ready;
   logic            wb_halt;
   logic            step;
   logic            pipe_reset;
   logic [2:0]      state;
   logic [BITS-1:0] cycle_count;
   logic            step_done;
   logic            cmd_error;
   logic            timeout;

   typedef struct {
      int         id;
      logic [2:0] st;
      int         cnt;
      logic       done;
      logic       err;
      logic       to;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   vec_id = 0;
   int   hc;
   logic hto;

   exp_t m_e;
   logic m_step, m_pr, m_rdy;

   always #5 clk = ~clk;

   pipeline_step_ctrl #(
      .BITS_SIZE      (BITS),
      .RESET_CYCLES   (4),
      .WATCHDOG_LIMIT (WD)
   ) dut (
      .i_clk         (clk),
      .i_reset       (rst),
      .i_cmd_valid   (cmd_valid),
      .i_cmd         (cmd),
      .o_cmd_ready   (cmd_ready),
      .i_wb_halt     (wb_halt),
      .o_step        (step),
      .o_pipe_reset  (pipe_reset),
      .o_state       (state),
      .o_cycle_count (cycle_count),
      .o_step_done   (step_done),
      .o_cmd_error   (cmd_error),
      .o_timeout     (timeout)
   );

   // Apply one cycle of inputs and queue the outputs expected after the edge.
   task automatic cyc(input logic r, input logic v, input logic [7:0] c, input logic h,
                      input logic [2:0] st, input int cnt, input logic done,
                      input logic err, input logic to);
      exp_t e;
      rst       = r;
      cmd_valid = v;
      cmd       = c;
      wb_halt   = h;
      @(posedge clk);
      #1;
      e.id   = vec_id;
      e.st   = st;
      e.cnt  = cnt;
      e.done = done;
      e.err  = err;
      e.to   = to;
      vec_id++;
      exp_q.push_back(e);
   endtask

   // Monitor: compare every queued expectation against the DUT mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         m_e   = exp_q.pop_front();
         m_step = (m_e.st == S_RUN) || (m_e.st == S_STEP);
         m_pr   = (m_e.st == S_PRE);
         m_rdy  = (m_e.st == S_IDLE) || (m_e.st == S_RUN) || (m_e.st == S_HALT);
         checks++;
         if (state !== m_e.st || step !== m_step || pipe_reset !== m_pr ||
             cmd_ready !== m_rdy || cycle_count !== BITS'(m_e.cnt) ||
             step_done !== m_e.done || cmd_error !== m_e.err || timeout !== m_e.to) begin
            errors++;
            $display("FAIL vec%0d: got st=%0d step=%b prst=%b rdy=%b cnt=%0d done=%b err=%b to=%b, need st=%0d step=%b prst=%b rdy=%b cnt=%0d done=%b err=%b to=%b",
                     m_e.id, state, step, pipe_reset, cmd_ready, cycle_count, step_done,
                     cmd_error, timeout, m_e.st, m_step, m_pr, m_rdy, m_e.cnt, m_e.done,
                     m_e.err, m_e.to);
         end
      end
   end

   initial begin
      // Reset values
      cyc(1, 0, 8'h00, 0, S_IDLE, 0, 0, 0, 0);
      cyc(1, 0, 8'h00, 0, S_IDLE, 0, 0, 0, 0);

      // Single step: one step cycle, count 1, one step_done pulse
      cyc(0, 1, C_S, 0, S_STEP, 0, 0, 0, 0);
      cyc(0, 0, 8'h00, 0, S_IDLE, 1, 1, 0, 0);
      cyc(0, 0, 8'h00, 0, S_IDLE, 1, 0, 0, 0);

`ifdef STEP_CTRL_WATCHDOG_EN
      // Watchdog: 8 RUN cycles then forced HALTED with sticky timeout
      cyc(0, 1, C_R, 0, S_RUN, 1, 0, 0, 0);
      for (int i = 1; i <= 7; i++) cyc(0, 0, 8'h00, 0, S_RUN, 1 + i, 0, 0, 0);
      cyc(0, 0, 8'h00, 0, S_HALT, 9, 0, 0, 1);
      hc  = 9;
      hto = 1'b1;
`else
      // Run 10 step cycles, halt on the 10th
      cyc(0, 1, C_R, 0, S_RUN, 1, 0, 0, 0);
      for (int i = 1; i <= 9; i++) cyc(0, 0, 8'h00, 0, S_RUN, 1 + i, 0, 0, 0);
      cyc(0, 0, 8'h00, 1, S_HALT, 11, 0, 0, 0);
      hc  = 11;
      hto = 1'b0;
`endif
      // HALTED holds; R, S and P are ignored
      cyc(0, 0, 8'h00, 0, S_HALT, hc, 0, 0, hto);
      cyc(0, 1, C_R, 0, S_HALT, hc, 0, 0, hto);
      cyc(0, 1, C_S, 0, S_HALT, hc, 0, 0, hto);
      cyc(0, 1, C_P, 0, S_HALT, hc, 0, 0, hto);

      // X from HALTED: four PRESET cycles, count and timeout cleared, S not taken
      cyc(0, 1, C_X, 0, S_PRE, 0, 0, 0, 0);
      cyc(0, 1, C_S, 0, S_PRE, 0, 0, 0, 0);
      cyc(0, 0, 8'h00, 0, S_PRE, 0, 0, 0, 0);
      cyc(0, 0, 8'h00, 0, S_PRE, 0, 0, 0, 0);
      cyc(0, 0, 8'h00, 0, S_IDLE, 0, 0, 0, 0);

      // P and halt on the same edge in RUN: halt wins
      cyc(0, 1, C_R, 0, S_RUN, 0, 0, 0, 0);
      cyc(0, 0, 8'h00, 0, S_RUN, 1, 0, 0, 0);
      cyc(0, 1, C_P, 1, S_HALT, 2, 0, 0, 0);
      cyc(0, 1, C_X, 0, S_PRE, 0, 0, 0, 0);
      cyc(0, 0, 8'h00, 0, S_PRE, 0, 0, 0, 0);
      cyc(0, 0, 8'h00, 0, S_PRE, 0, 0, 0, 0);
      cyc(0, 0, 8'h00, 0, S_PRE, 0, 0, 0, 0);
      cyc(0, 0, 8'h00, 0, S_IDLE, 0, 0, 0, 0);

      // Unknown byte: one error pulse, no state change (IDLE and RUN)
      cyc(0, 1, C_BAD, 0, S_IDLE, 0, 0, 1, 0);
      cyc(0, 0, 8'h00, 0, S_IDLE, 0, 0, 0, 0);
      cyc(0, 1, C_R, 0, S_RUN, 0, 0, 0, 0);
      cyc(0, 1, C_BAD, 0, S_RUN, 1, 0, 1, 0);
      cyc(0, 1, C_P, 0, S_IDLE, 2, 0, 0, 0);
      cyc(0, 1, C_P, 0, S_IDLE, 2, 0, 0, 0);

      // Reset in the 2nd PRESET cycle
      cyc(0, 1, C_X, 0, S_PRE, 0, 0, 0, 0);
      cyc(0, 0, 8'h00, 0, S_PRE, 0, 0, 0, 0);
      cyc(1, 0, 8'h00, 0, S_IDLE, 0, 0, 0, 0);
      cyc(0, 0, 8'h00, 0, S_IDLE, 0, 0, 0, 0);

      // Reset mid-STEP: no step_done afterwards
      cyc(0, 1, C_S, 0, S_STEP, 0, 0, 0, 0);
      cyc(1, 0, 8'h00, 0, S_IDLE, 0, 0, 0, 0);
      cyc(0, 0, 8'h00, 0, S_IDLE, 0, 0, 0, 0);

`ifndef STEP_CTRL_WATCHDOG_EN
      // Cycle counter saturates at all-ones (4-bit counter here)
      cyc(0, 1, C_R, 0, S_RUN, 0, 0, 0, 0);
      for (int i = 1; i <= 18; i++) cyc(0, 0, 8'h00, 0, S_RUN, (i > 15) ? 15 : i, 0, 0, 0);
      cyc(0, 1, C_P, 0, S_IDLE, 15, 0, 0, 0);
      cyc(0, 0, 8'h00, 0, S_IDLE, 15, 0, 0, 0);
`endif

      cmd_valid = 1'b0;
      rst       = 1'b0;
      wb_halt   = 1'b0;
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, need 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
